line_fill_responder: RTL

//  Main-memory side of the cache line-fill interface. Accepts one line request at a time

---
 rtl/line_fill_responder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/line_fill_responder.sv
// ============================================================================
// Module   : line_fill_responder
// Purpose  : Main-memory side of the cache line-fill interface. Serves one
//            line request at a time. A read returns a full line, one word
//            per cycle, LATENCY cycles after accept. A write absorbs one
//            line of strobed words and answers with a one-cycle acknowledge.
//            The backing store is a word array that is never reset.
// Ports    : CLK, RST        clock / synchronous active-high reset
//            req_valid/ready request handshake (req_ready is combinational)
//            req_write       1 = writeback, 0 = line fill
//            req_addr        byte address; low line-offset bits select the
//                            critical word when that option is built in
//            wr_valid/data   writeback word strobe and data
//            rsp_valid/data  read word or write ack (data 0 on ack)
//            rsp_word_idx    word offset within the line of rsp_data
//            rsp_last        final read word, or write ack
//            busy            inverse of req_ready
// Options  : RESP_CRITICAL_WORD_FIRST_EN - read bursts start at the requested
//            word and wrap around the line. Undefined: bursts start at 0.
//            MEM_INIT names a preload image for environments that load the
//            array externally; this model starts with unspecified contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_responder #(
  parameter int WORDS_PER_LINE  = 8,
  parameter int MEM_DEPTH_WORDS = 4096,
  parameter int LATENCY         = 4,
  parameter     MEM_INIT        = ""
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [31:0]                       req_addr,
  input  logic                              wr_valid,
  input  logic [31:0]                       wr_data,
  output logic                              rsp_valid,
  output logic [31:0]                       rsp_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] rsp_word_idx,
  output logic                              rsp_last,
  output logic                              busy
);

  localparam int c_widx = $clog2(WORDS_PER_LINE);
  localparam int c_aw   = $clog2(MEM_DEPTH_WORDS);
  localparam int c_lw   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [c_widx-1:0] c_beat_last = c_widx'(WORDS_PER_LINE - 1);
  localparam logic [c_widx-1:0] c_beat_pen  = c_widx'(WORDS_PER_LINE - 2);
  localparam logic [c_lw-1:0]   c_lat_last  = c_lw'(LATENCY - 2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  logic [31:0]       mem_q [MEM_DEPTH_WORDS];

  logic [2:0]        state_q, state_d;
  logic [c_lw-1:0]   lat_q, lat_d;
  logic [c_widx-1:0] beat_q, beat_d;    // read beat on display / write word count
  logic [c_aw-1:0]   base_q, base_d;    // word index of the line base
  logic [c_widx-1:0] start_q, start_d;  // first offset of the read burst
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic [c_widx-1:0] rsp_idx_q, rsp_idx_d;
  logic [31:0]       rsp_data_q;

  logic              w_accept;
  logic [c_aw-1:0]   w_req_base;
  logic [c_widx-1:0] w_req_start;
  logic              w_rd_en;
  logic [c_aw-1:0]   w_rd_base;
  logic [c_widx-1:0] w_rd_off;
  logic [c_aw-1:0]   w_rd_addr;
  logic              w_wr_en;
  logic [c_aw-1:0]   w_wr_addr;
  logic              w_unused_addr;

  assign req_ready = (state_q == S_IDLE) & ~RST;
  assign busy      = ~req_ready;
  assign w_accept  = req_valid & req_ready;

  // Line base as a word index; bits above the array depth wrap away.
  assign w_req_base = {req_addr[c_aw+1:c_widx+2], {c_widx{1'b0}}};

`ifdef RESP_CRITICAL_WORD_FIRST_EN
  assign w_req_start = req_addr[c_widx+1:2];
`else
  assign w_req_start = '0;
`endif

  // Byte-lane bits and high address bits are intentionally dropped.
  assign w_unused_addr = ^req_addr;

  // Base is line aligned, so adding the offset never carries out of the line.
  assign w_rd_addr = w_rd_base + {{(c_aw - c_widx){1'b0}}, w_rd_off};
  assign w_wr_addr = base_q + {{(c_aw - c_widx){1'b0}}, beat_q};
  assign w_wr_en   = (state_q == S_WR) & wr_valid & ~RST;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    base_d      = base_q;
    start_d     = start_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_idx_d   = '0;
    w_rd_en     = 1'b0;
    w_rd_base   = base_q;
    w_rd_off    = start_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          base_d  = w_req_base;
          start_d = w_req_start;
          lat_d   = '0;
          beat_d  = '0;
          if (req_write) begin
            state_d = S_WR;
          end else if (LATENCY == 1) begin
            // Zero wait cycles: the first word is launched at the accept edge.
            state_d     = S_RD;
            w_rd_en     = 1'b1;
            w_rd_base   = w_req_base;
            w_rd_off    = w_req_start;
            rsp_valid_d = 1'b1;
            rsp_idx_d   = w_req_start;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (lat_q == c_lat_last) begin
          state_d     = S_RD;
          lat_d       = '0;
          w_rd_en     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_idx_d   = start_q;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      // beat_q is the beat currently on the outputs; each edge launches the next.
      S_RD: begin
        if (beat_q == c_beat_last) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d      = beat_q + 1'b1;
          w_rd_off    = start_q + beat_d;
          w_rd_en     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_idx_d   = w_rd_off;
          rsp_last_d  = (beat_q == c_beat_pen);
        end
      end

      S_WR: begin
        if (wr_valid) begin
          if (beat_q == c_beat_last) begin
            state_d     = S_ACK;
            beat_d      = '0;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      start_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_data_q  <= w_rd_en ? mem_q[w_rd_addr] : 32'd0;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      mem_q[w_wr_addr] <= wr_data;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_last     = rsp_last_q;
  assign rsp_word_idx = rsp_idx_q;
  assign rsp_data     = rsp_data_q;

endmodule

`default_nettype wire
